// File: rtl/parity_scoreboard_9bit.sv
// rtl/parity_scoreboard_9bit.sv - 9-bit parity checker scoreboard over one 512-word counter sweep
// Optional macro PARITY_SEQ_CHECK_EN adds sticky sequence-break detection on the counter words.
module parity_scoreboard_9bit #(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            valid,
  input  logic [8:0]      data,
  input  logic            dut_even,
  input  logic            dut_odd,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic            first_err_valid,
  output logic [8:0]      first_err_data,
  output logic            seq_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      word_cnt_q, word_cnt_d;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            first_err_valid_q, first_err_valid_d;
  logic [8:0]      first_err_data_q, first_err_data_d;
  logic            seq_err_q;

  logic ref_even, ref_odd;
  logic accept, mismatch;

  assign ref_even = ~^data;
  assign ref_odd  = ^data;
  assign mismatch = (dut_even != ref_even) || (dut_odd != ref_odd);

  // IDLE only accepts word 0 so the sweep always starts aligned.
  assign accept = valid && (((state_q == S_IDLE) && (data == 9'd0)) || (state_q == S_RUN));

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid && (data == 9'd0)) state_d = S_RUN;
      S_RUN:   if (valid && (word_cnt_q == 10'd511)) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    pass = done && (err_cnt_q == '0) && !seq_err_q;
  end

  always_comb begin
    word_cnt_d        = word_cnt_q;
    err_cnt_d         = err_cnt_q;
    first_err_valid_d = first_err_valid_q;
    first_err_data_d  = first_err_data_q;
    if (accept) begin
      word_cnt_d = word_cnt_q + 10'd1;
      if (mismatch) begin
        if (err_cnt_q != {ERRW{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        if (!first_err_valid_q) begin
          first_err_valid_d = 1'b1;
          first_err_data_d  = data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      word_cnt_q        <= '0;
      err_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_data_q  <= '0;
    end else begin
      word_cnt_q        <= word_cnt_d;
      err_cnt_q         <= err_cnt_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_data_q  <= first_err_data_d;
    end
  end

`ifdef PARITY_SEQ_CHECK_EN
  logic [8:0] exp_data_q, exp_data_d;
  logic       seq_err_d;

  // Expected word resyncs to data + 1 after every accepted word, break or not.
  always_comb begin
    exp_data_d = exp_data_q;
    seq_err_d  = seq_err_q;
    if (accept) begin
      exp_data_d = data + 9'd1;
      if ((state_q == S_RUN) && (data != exp_data_q)) seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      exp_data_q <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      exp_data_q <= exp_data_d;
      seq_err_q  <= seq_err_d;
    end
  end
`else
  assign seq_err_q = 1'b0;
`endif

  assign err_count       = err_cnt_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_data  = first_err_data_q;
  assign seq_err         = seq_err_q;

endmodule

// File: tb/tb_parity_scoreboard_9bit.sv
// tb/tb_parity_scoreboard_9bit.sv - scoreboard bench for parity_scoreboard_9bit (ERRW 8 and ERRW 2 instances)
module tb_parity_scoreboard_9bit;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       valid = 1'b0;
  logic [8:0] data = '0;
  logic       dut_even = 1'b0;
  logic       dut_odd = 1'b0;

  logic       busy, done, pass, fev, seq;
  logic [7:0] err;
  logic [8:0] fed;
  logic       busy2, done2, pass2, fev2, seq2;
  logic [1:0] err2;
  logic [8:0] fed2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  parity_scoreboard_9bit #(.ERRW(8)) dut (
    .clk(clk), .clear(clear), .valid(valid), .data(data),
    .dut_even(dut_even), .dut_odd(dut_odd),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_err_valid(fev), .first_err_data(fed), .seq_err(seq)
  );

  parity_scoreboard_9bit #(.ERRW(2)) dut2 (
    .clk(clk), .clear(clear), .valid(valid), .data(data),
    .dut_even(dut_even), .dut_odd(dut_odd),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(fev2), .first_err_data(fed2), .seq_err(seq2)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [1:0] err2;
    logic       pass2;
    logic       fev;
    logic [8:0] fed;
    logic       seq;
  } snap_t;

  snap_t exp_q[$];

  int         m_state = 0;
  int         m_cnt = 0;
  int         m_err = 0;
  int         m_err2 = 0;
  logic       m_fev = 1'b0;
  logic [8:0] m_fed = '0;
  logic       m_seq = 1'b0;
  logic [8:0] m_exp = '0;

`ifdef PARITY_SEQ_CHECK_EN
  localparam logic SEQ_ON = 1'b1;
`else
  localparam logic SEQ_ON = 1'b0;
`endif

  task automatic model_check(input logic [8:0] d, input logic ev, input logic od);
    logic e_ref, o_ref;
    e_ref = ~^d;
    o_ref = ^d;
    if (ev != e_ref || od != o_ref) begin
      if (m_err < 255) m_err++;
      if (m_err2 < 3) m_err2++;
      if (!m_fev) begin
        m_fev = 1'b1;
        m_fed = d;
      end
    end
  endtask

  // Applies one cycle of stimulus; the expected post-edge snapshot is queued for the monitor.
  task automatic drive(input logic v, input logic [8:0] d, input logic ev, input logic od, input logic clr);
    snap_t s;
    clear = clr;
    valid = v;
    data = d;
    dut_even = ev;
    dut_odd = od;
    @(posedge clk);
    if (clr) begin
      m_state = 0; m_cnt = 0; m_err = 0; m_err2 = 0;
      m_fev = 1'b0; m_fed = '0; m_seq = 1'b0; m_exp = '0;
    end else if (v) begin
      if (m_state == 0 && d == 9'd0) begin
        m_state = 1;
        m_cnt = 1;
        m_exp = 9'd1;
        model_check(d, ev, od);
      end else if (m_state == 1) begin
        if (SEQ_ON && d != m_exp) m_seq = 1'b1;
        m_exp = d + 9'd1;
        m_cnt++;
        model_check(d, ev, od);
        if (m_cnt == 512) m_state = 2;
      end
    end
    s.busy  = (m_state == 1);
    s.done  = (m_state == 2);
    s.pass  = (m_state == 2) && (m_err == 0) && !m_seq;
    s.err   = 8'(m_err);
    s.err2  = 2'(m_err2);
    s.pass2 = (m_state == 2) && (m_err2 == 0) && !m_seq;
    s.fev   = m_fev;
    s.fed   = m_fed;
    s.seq   = m_seq;
    exp_q.push_back(s);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    snap_t got, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = {busy, done, pass, err, err2, pass2, fev, fed, seq};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, got, want);
      end
    end
  end

  task automatic good(input logic [8:0] d);
    drive(1'b1, d, ~^d, ^d, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b1, 9'h1FF, 1'b1, 1'b1, 1'b1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 9'd0, 1'b1, 1'b1, 1'b1);
    total++;
    if ({busy, done, pass, fev, seq} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b expected=00000", {busy, done, pass, fev, seq});
    end
    total++;
    if (err !== 8'd0 || fed !== 9'd0) begin
      bad++; $display("FAIL reset_regs got err=%0d fed=%h expected 0 0", err, fed);
    end
  endtask

  task automatic test_good_sweep();
    do_clear();
    for (int i = 0; i < 511; i++) good(9'(i));
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL good_pre_done got busy=%b done=%b expected 1 0", busy, done);
    end
    good(9'd511);
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || err !== 8'd0 || fev !== 1'b0) begin
      bad++; $display("FAIL good_done got done=%b pass=%b err=%0d fev=%b expected 1 1 0 0", done, pass, err, fev);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 9'(i), 1'b1, 1'b1, 1'b0);
    total++;
    if (err !== 8'd0 || pass !== 1'b1) begin
      bad++; $display("FAIL good_done_hold got err=%0d pass=%b expected 0 1", err, pass);
    end
  endtask

  task automatic test_single_error();
    do_clear();
    for (int i = 0; i < 512; i++) begin
      if (i == 9'h0A5) drive(1'b1, 9'(i), ^9'(i), ^9'(i), 1'b0);
      else good(9'(i));
    end
    total++;
    if (err !== 8'd1 || fev !== 1'b1 || fed !== 9'h0A5 || pass !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL single_err got err=%0d fev=%b fed=%h pass=%b done=%b expected 1 1 0a5 0 1", err, fev, fed, pass, done);
    end
  endtask

  task automatic test_saturate();
    do_clear();
    for (int i = 0; i < 512; i++) drive(1'b1, 9'(i), 1'b1, 1'b1, 1'b0);
    total++;
    if (err2 !== 2'd3 || done2 !== 1'b1 || pass2 !== 1'b0) begin
      bad++; $display("FAIL sat_errw2 got err=%0d done=%b pass=%b expected 3 1 0", err2, done2, pass2);
    end
    total++;
    if (err !== 8'd255 || fed !== 9'd0 || fev !== 1'b1) begin
      bad++; $display("FAIL sat_errw8 got err=%0d fed=%h fev=%b expected 255 000 1", err, fed, fev);
    end
  endtask

  task automatic test_sync_and_gaps();
    do_clear();
    for (int i = 100; i < 130; i++) good(9'(i));
    total++;
    if (busy !== 1'b0 || err !== 8'd0) begin
      bad++; $display("FAIL sync_idle got busy=%b err=%0d expected 0 0", busy, err);
    end
    for (int i = 0; i < 512; i++) begin
      drive(1'b0, 9'($urandom_range(0, 511)), 1'b1, 1'b1, 1'b0);
      if (i == 511) begin
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL gaps_pre_done got done=%b busy=%b expected 0 1", done, busy);
        end
      end
      good(9'(i));
    end
    total++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      bad++; $display("FAIL gaps_done got done=%b pass=%b expected 1 1", done, pass);
    end
  endtask

  task automatic test_clear_mid();
    do_clear();
    for (int i = 0; i < 300; i++) begin
      if (i == 50) drive(1'b1, 9'(i), 1'b0, 1'b0, 1'b0);
      else good(9'(i));
    end
    drive(1'b1, 9'd300, 1'b1, 1'b1, 1'b1);
    clear = 1'b0;
    total++;
    if ({busy, done, pass, fev, seq} !== 5'b0 || err !== 8'd0 || fed !== 9'd0) begin
      bad++; $display("FAIL clear_mid got flags=%b err=%0d fed=%h expected 00000 0 000", {busy, done, pass, fev, seq}, err, fed);
    end
    for (int i = 0; i < 512; i++) good(9'(i));
    total++;
    if (pass !== 1'b1 || done !== 1'b1) begin
      bad++; $display("FAIL clear_resweep got pass=%b done=%b expected 1 1", pass, done);
    end
  endtask

  task automatic test_seq_skip();
    do_clear();
    for (int i = 0; i < 512; i++) if (i != 8) good(9'(i));
    good(9'd0);
    total++;
    if (seq !== SEQ_ON || err !== 8'd0 || done !== 1'b1 || pass !== !SEQ_ON) begin
      bad++; $display("FAIL seq_skip got seq=%b err=%0d done=%b pass=%b expected %b 0 1 %b", seq, err, done, pass, SEQ_ON, !SEQ_ON);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_good_sweep();
    test_single_error();
    test_saturate();
    test_sync_and_gaps();
    test_clear_mid();
    test_seq_skip();
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
